jtframe_romshare_arb: RTL and testbench

- Arbiter that shares one SDRAM/BRAM ROM slot between two requesters.
- Requester A is the main CPU ROM bus. Requester B is the MCU program ROM, i.e. the rom_addr/rom_cs/rom_ok side of the MCU wrapper's cen-gating logic.
- Latches the winning address and holds downstream cs until data returns.
- Returns data and ok only to the granted requester, with round-robin fairness on contention.

---
 rtl/jtframe_romarb_pkg.sv | 24 ++
 rtl/jtframe_romarb_hit.sv | 63 ++++++
 rtl/jtframe_romshare_arb.sv | 131 +++++++++++++
 tb/tb_jtframe_romshare_arb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_romarb_pkg.sv
// Shared types for the two-requester ROM slot arbiter: FSM states, requester ids
// and the hit-register entry layout.
package jtframe_romarb_pkg;

  localparam int unsigned ROMARB_AW = 17;
  localparam int unsigned ROMARB_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_A,
    BUSY_B,
    GAP
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef struct packed {
    logic                 valid;
    logic [ROMARB_AW-1:0] addr;
    logic [ROMARB_DW-1:0] data;
  } hit_entry_t;

endpackage

// File: rtl/jtframe_romarb_hit.sv
// Per-requester hit store: a single register cleared while cs is low, or, with
// JTFRAME_ROMARB_CACHE_EN defined, a 4-entry direct-mapped cache cleared only by rst.
module jtframe_romarb_hit
  import jtframe_romarb_pkg::*;
#(
  parameter int unsigned AW = ROMARB_AW,
  parameter int unsigned DW = ROMARB_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  output logic          ok,
  output logic [DW-1:0] data
);

`ifdef JTFRAME_ROMARB_CACHE_EN
  localparam int unsigned NSETS = 4;

  hit_entry_t r_ent [NSETS];
  logic [1:0] w_idx;
  logic [1:0] w_fill_idx;

  assign w_idx      = addr[1:0];
  assign w_fill_idx = fill_addr[1:0];

  // Full address is stored, so comparing it also covers the addr[AW-1:2] tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSETS; i++) r_ent[i] <= '0;
    end else if (fill) begin
      r_ent[w_fill_idx] <= '{valid: 1'b1,
                             addr:  ROMARB_AW'(fill_addr),
                             data:  ROMARB_DW'(fill_data)};
    end
  end

  assign ok   = cs & r_ent[w_idx].valid & (AW'(r_ent[w_idx].addr) == addr);
  assign data = DW'(r_ent[w_idx].data);
`else
  hit_entry_t r_ent;

  // A fill landing while cs is low still records addr/data but stays invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ent <= '0;
    end else begin
      if (fill) begin
        r_ent.addr <= ROMARB_AW'(fill_addr);
        r_ent.data <= ROMARB_DW'(fill_data);
      end
      r_ent.valid <= cs & (fill | r_ent.valid);
    end
  end

  assign ok   = cs & r_ent.valid & (AW'(r_ent.addr) == addr);
  assign data = DW'(r_ent.data);
`endif

endmodule

// File: rtl/jtframe_romshare_arb.sv
// Round-robin arbiter sharing one ROM slot between the main CPU (A) and the MCU (B).
// Optional per-requester cache enabled by JTFRAME_ROMARB_CACHE_EN.
module jtframe_romshare_arb
  import jtframe_romarb_pkg::*;
#(
  parameter int unsigned AW     = ROMARB_AW,
  parameter int unsigned DW     = ROMARB_DW,
  parameter bit          PRIO_B = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] a_addr,
  input  logic          a_cs,
  output logic          a_ok,
  output logic [DW-1:0] a_data,
  input  logic [AW-1:0] b_addr,
  input  logic          b_cs,
  output logic          b_ok,
  output logic [DW-1:0] b_data,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic          rom_ok,
  input  logic [DW-1:0] rom_data
);

  state_t        r_state, w_state_nxt;
  logic          r_rom_cs, w_rom_cs_nxt;
  logic [AW-1:0] r_rom_addr, w_rom_addr_nxt;
  logic          r_last, w_last_nxt;
  logic          r_first, w_first_nxt;
  logic          w_fill_a, w_fill_b;
  logic          w_need_a, w_need_b;
  logic          w_grant_a, w_grant_b;
  logic          w_honour;

  assign w_need_a = a_cs & ~a_ok;
  assign w_need_b = b_cs & ~b_ok;
  // rom_ok during the first busy cycle may belong to the previous address.
  assign w_honour = rom_ok & ~r_first;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rom_cs   <= 1'b0;
      r_rom_addr <= '0;
      r_last     <= ~PRIO_B;
      r_first    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rom_cs   <= w_rom_cs_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_last     <= w_last_nxt;
      r_first    <= w_first_nxt;
    end
  end

  // GAP arbitrates like IDLE so rom_cs is low exactly one cycle between transfers.
  always_comb begin
    w_state_nxt    = r_state;
    w_rom_cs_nxt   = r_rom_cs;
    w_rom_addr_nxt = r_rom_addr;
    w_last_nxt     = r_last;
    w_first_nxt    = 1'b0;
    w_fill_a       = 1'b0;
    w_fill_b       = 1'b0;
    w_grant_a      = w_need_a & (~w_need_b | (r_last == REQ_B));
    w_grant_b      = w_need_b & ~w_grant_a;
    unique case (r_state)
      IDLE, GAP: begin
        w_rom_cs_nxt = 1'b0;
        w_state_nxt  = IDLE;
        if (w_grant_a) begin
          w_state_nxt    = BUSY_A;
          w_rom_cs_nxt   = 1'b1;
          w_rom_addr_nxt = a_addr;
          w_first_nxt    = 1'b1;
        end else if (w_grant_b) begin
          w_state_nxt    = BUSY_B;
          w_rom_cs_nxt   = 1'b1;
          w_rom_addr_nxt = b_addr;
          w_first_nxt    = 1'b1;
        end
      end
      BUSY_A: begin
        if (w_honour) begin
          w_fill_a     = 1'b1;
          w_rom_cs_nxt = 1'b0;
          w_last_nxt   = REQ_A;
          w_state_nxt  = GAP;
        end
      end
      BUSY_B: begin
        if (w_honour) begin
          w_fill_b     = 1'b1;
          w_rom_cs_nxt = 1'b0;
          w_last_nxt   = REQ_B;
          w_state_nxt  = GAP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign rom_cs   = r_rom_cs;
  assign rom_addr = r_rom_addr;

  jtframe_romarb_hit #(.AW(AW), .DW(DW)) u_hit_a (
    .clk       (clk),
    .rst       (rst),
    .cs        (a_cs),
    .addr      (a_addr),
    .fill      (w_fill_a),
    .fill_addr (r_rom_addr),
    .fill_data (rom_data),
    .ok        (a_ok),
    .data      (a_data)
  );

  jtframe_romarb_hit #(.AW(AW), .DW(DW)) u_hit_b (
    .clk       (clk),
    .rst       (rst),
    .cs        (b_cs),
    .addr      (b_addr),
    .fill      (w_fill_b),
    .fill_addr (r_rom_addr),
    .fill_data (rom_data),
    .ok        (b_ok),
    .data      (b_data)
  );

endmodule

// File: tb/tb_jtframe_romshare_arb.sv
// Directed bench for jtframe_romshare_arb; covers both builds of JTFRAME_ROMARB_CACHE_EN.
module tb_jtframe_romshare_arb;

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst;
  logic [AW-1:0] a_addr, b_addr;
  logic          a_cs, b_cs;
  logic          a_ok, b_ok;
  logic [DW-1:0] a_data, b_data;
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic          rom_ok;
  logic [DW-1:0] rom_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW-1:0] a_cur, b_cur;
  logic          exp_b_win;
  logic [DW-1:0] d;

  jtframe_romshare_arb #(.AW(AW), .DW(DW), .PRIO_B(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_addr   (a_addr),
    .a_cs     (a_cs),
    .a_ok     (a_ok),
    .a_data   (a_data),
    .b_addr   (b_addr),
    .b_cs     (b_cs),
    .b_ok     (b_ok),
    .b_data   (b_data),
    .rom_addr (rom_addr),
    .rom_cs   (rom_cs),
    .rom_ok   (rom_ok),
    .rom_data (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait n busy cycles, then present rom_ok for one cycle; ends in the GAP cycle.
  task automatic reply(input int n, input logic [DW-1:0] dat);
    repeat (n) tick();
    rom_ok   = 1'b1;
    rom_data = dat;
    tick();
    rom_ok   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; a_cs = 1'b0; b_cs = 1'b0; a_addr = '0; b_addr = '0;
    rom_ok = 1'b0; rom_data = '0;
    tick(); tick();
    chk("rst_rom_cs", 32'(rom_cs), 32'h0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_a_ok", 32'(a_ok), 32'h0);
    chk("rst_b_ok", 32'(b_ok), 32'h0);
    chk("rst_a_data", 32'(a_data), 32'h0);
    rst = 1'b0;

    // Single requester A, rom_ok 3 cycles after rom_cs rises
    a_cs = 1'b1; a_addr = 17'h100;
    #1 chk("t1_cs_before_grant", 32'(rom_cs), 32'h0);
    tick();
    chk("t1_rom_addr", 32'(rom_addr), 32'h100);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1_rom_cs_c%0d", i + 1), 32'(rom_cs), 32'h1);
      tick();
    end
    chk("t1_rom_cs_c4", 32'(rom_cs), 32'h1);
    rom_ok = 1'b1; rom_data = 8'h5A;
    #1 chk("t1_a_ok_early", 32'(a_ok), 32'h0);
    tick();
    rom_ok = 1'b0;
    chk("t1_rom_cs_gap", 32'(rom_cs), 32'h0);
    chk("t1_a_ok", 32'(a_ok), 32'h1);
    chk("t1_a_data", 32'(a_data), 32'h5A);
    chk("t1_b_ok", 32'(b_ok), 32'h0);
    tick(); tick();
    chk("t1_hit_no_rom", 32'(rom_cs), 32'h0);
    chk("t1_hit_ok", 32'(a_ok), 32'h1);
    a_addr = 17'h101;
    #1 chk("t1_addr_change_ok", 32'(a_ok), 32'h0);
    a_cs = 1'b0;
    tick();

    // Contention right after reset: B first, one-cycle gap, then A
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_cs = 1'b1; a_addr = 17'h010;
    b_cs = 1'b1; b_addr = 17'h020;
    tick();
    chk("t2_first_addr", 32'(rom_addr), 32'h020);
    chk("t2_first_cs", 32'(rom_cs), 32'h1);
    reply(1, 8'hB2);
    chk("t2_gap_cs", 32'(rom_cs), 32'h0);
    chk("t2_b_ok", 32'(b_ok), 32'h1);
    chk("t2_b_data", 32'(b_data), 32'hB2);
    chk("t2_a_wait", 32'(a_ok), 32'h0);
    tick();
    chk("t2_second_cs", 32'(rom_cs), 32'h1);
    chk("t2_second_addr", 32'(rom_addr), 32'h010);
    reply(1, 8'hA1);
    chk("t2_a_ok", 32'(a_ok), 32'h1);
    chk("t2_a_data", 32'(a_data), 32'hA1);
    chk("t2_b_still_ok", 32'(b_ok), 32'h1);

    // Round robin: both keep requesting new addresses
    a_cur = 17'h200; b_cur = 17'h300;
    a_addr = a_cur; b_addr = b_cur;
    for (int i = 0; i < 8; i++) begin
      exp_b_win = (i % 2 == 0);
      d = 8'(8'h30 + i);
      tick();
      chk($sformatf("t3_cs_%0d", i), 32'(rom_cs), 32'h1);
      chk($sformatf("t3_addr_%0d", i), 32'(rom_addr), exp_b_win ? 32'(b_cur) : 32'(a_cur));
      reply(1, d);
      if (exp_b_win) begin
        chk($sformatf("t3_b_data_%0d", i), 32'(b_ok ? b_data : 8'h00), 32'(d));
        b_cur = b_cur + 17'h1; b_addr = b_cur;
      end else begin
        chk($sformatf("t3_a_data_%0d", i), 32'(a_ok ? a_data : 8'h00), 32'(d));
        a_cur = a_cur + 17'h1; a_addr = a_cur;
      end
    end
    a_cs = 1'b0; b_cs = 1'b0;
    tick();

    // Stale rom_ok carried from B's transfer into A's first busy cycle
    b_cs = 1'b1; b_addr = 17'h500;
    tick();
    tick();
    rom_ok = 1'b1; rom_data = 8'hEE;
    a_cs = 1'b1; a_addr = 17'h400;
    tick();
    chk("t4_b_ok", 32'(b_ok), 32'h1);
    chk("t4_b_data", 32'(b_data), 32'hEE);
    tick();
    chk("t4_a_cs", 32'(rom_cs), 32'h1);
    chk("t4_a_addr", 32'(rom_addr), 32'h400);
    tick();
    chk("t4_stale_masked", 32'(rom_cs), 32'h1);
    chk("t4_a_not_ok", 32'(a_ok), 32'h0);
    rom_data = 8'h77;
    tick();
    rom_ok = 1'b0;
    chk("t4_gap_cs", 32'(rom_cs), 32'h0);
    chk("t4_a_data", 32'(a_ok ? a_data : 8'h00), 32'h77);
    a_cs = 1'b0; b_cs = 1'b0;
    tick();

    // B abandons its request one cycle after grant
    b_cs = 1'b1; b_addr = 17'h600;
    tick();
    chk("t5_grant_addr", 32'(rom_addr), 32'h600);
    b_cs = 1'b0;
    tick();
    chk("t5_cs_held", 32'(rom_cs), 32'h1);
    tick();
    rom_ok = 1'b1; rom_data = 8'h66;
    tick();
    rom_ok = 1'b0;
    chk("t5_gap_cs", 32'(rom_cs), 32'h0);
    chk("t5_b_ok_dropped", 32'(b_ok), 32'h0);
    tick();
    b_cs = 1'b1;
`ifdef JTFRAME_ROMARB_CACHE_EN
    #1 chk("t5_cache_hit", 32'(b_ok), 32'h1);
    chk("t5_cache_data", 32'(b_data), 32'h66);
    tick();
    chk("t5_cache_no_rom", 32'(rom_cs), 32'h0);
`else
    #1 chk("t5_no_hit", 32'(b_ok), 32'h0);
    tick();
    chk("t5_refetch_cs", 32'(rom_cs), 32'h1);
    chk("t5_refetch_addr", 32'(rom_addr), 32'h600);
    reply(1, 8'h67);
    chk("t5_refetch_data", 32'(b_ok ? b_data : 8'h00), 32'h67);
`endif
    b_cs = 1'b0;
    tick();

    // Reset during BUSY_A, late rom_ok one cycle after release
    a_cs = 1'b1; a_addr = 17'h700;
    tick();
    chk("t6_busy", 32'(rom_cs), 32'h1);
    tick();
    rst = 1'b1; a_cs = 1'b0;
    tick();
    rst = 1'b0;
    rom_ok = 1'b1; rom_data = 8'h99;
    tick();
    rom_ok = 1'b0;
    chk("t6_rom_cs", 32'(rom_cs), 32'h0);
    chk("t6_rom_addr", 32'(rom_addr), 32'h0);
    chk("t6_b_ok", 32'(b_ok), 32'h0);
    a_cs = 1'b1;
    #1 chk("t6_a_no_hit", 32'(a_ok), 32'h0);
    tick();
    chk("t6_new_req", 32'(rom_cs), 32'h1);
    a_cs = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
